// File: rtl/cipher_sched_pkg.sv
// Shared state encodings, datapath control codes and defaults for cipher_sched.
package cipher_sched_pkg;

   localparam int STATE_W   = 3;
   localparam int LEN_W_DEF = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'b000,
      ST_KEY_GEN_1 = 3'b001,
      ST_KEY_GEN_2 = 3'b010,
      ST_RUN       = 3'b011,
      ST_DONE      = 3'b100
   } state_t;

   // Control codes are packed as {key_gen, outcode}
   typedef logic [1:0] ctrl_t;
   localparam ctrl_t CTRL_IDLE   = 2'b00;
   localparam ctrl_t CTRL_KEYGEN = 2'b10;
   localparam ctrl_t CTRL_ENC    = 2'b01;
   localparam ctrl_t CTRL_DEC    = 2'b11;

   function automatic ctrl_t ctrl_for(input state_t s, input logic enc);
      ctrl_t c;
      c = CTRL_IDLE;
      case (s)
         ST_KEY_GEN_1, ST_KEY_GEN_2: c = CTRL_KEYGEN;
         ST_RUN:                     c = enc ? CTRL_ENC : CTRL_DEC;
         default:                    c = CTRL_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cipher_sched_rr_arb2.sv
// Two-request round-robin arbiter; the requester the pointer names loses a tie.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win,
   output logic       id
);

   always_comb begin
      win = 2'b00;
      id  = 1'b0;
      if (req == 2'b11) begin
         id  = ~ptr;
         win = {~ptr, ptr};
      end else if (req != 2'b00) begin
         id  = req[1];
         win = req;
      end
   end

endmodule

// File: rtl/cipher_sched.sv
// Shares one cipher datapath between two requesters: arbitrate, key-gen twice, stream words.
// Optional stall timeout is built when CIPHER_SCHED_TIMEOUT_EN is defined.
module cipher_sched
   import cipher_sched_pkg::*;
#(
   parameter int LEN_W   = LEN_W_DEF,
   parameter int TMO_CYC = 16
) (
   input  logic               clka,
   input  logic               restart,
   input  logic [1:0]         req,
   input  logic [1:0]         mode,
   input  logic [2*LEN_W-1:0] len,
   input  logic               dp_ready,
   output logic [1:0]         gnt,
   output logic               key_gen,
   output logic               outcode,
   output logic               word_vld,
   output logic [1:0]         done,
   output logic               busy,
   output logic [2:0]         state,
   output logic               err
);

   state_t             cur_state;
   state_t             nxt_state;
   logic               owner_id;
   logic               owner_mode;
   logic [LEN_W-1:0]   word_cnt;
   logic               rr_ptr;
   logic [1:0]         arb_win;
   logic               arb_id;
   logic               take_grant;
   logic               abort;
   logic               timeout;
   logic               sel_id;
   logic               sel_mode;
   logic               owns_dp;

   rr_arb2 u_arb (
      .req (req),
      .ptr (rr_ptr),
      .win (arb_win),
      .id  (arb_id)
   );

`ifdef CIPHER_SCHED_TIMEOUT_EN
   localparam int STALL_W = $clog2(TMO_CYC + 1);
   logic [STALL_W-1:0] stall_cnt;
`endif

   assign owns_dp = (cur_state == ST_KEY_GEN_1) || (cur_state == ST_KEY_GEN_2) ||
                    (cur_state == ST_RUN);

   always_comb begin
      nxt_state  = cur_state;
      take_grant = 1'b0;
      abort      = 1'b0;
      timeout    = 1'b0;
      case (cur_state)
         ST_IDLE: begin
            if (arb_win != 2'b00) begin
               take_grant = 1'b1;
               nxt_state  = ST_KEY_GEN_1;
            end
         end
         ST_KEY_GEN_1: nxt_state = ST_KEY_GEN_2;
         ST_KEY_GEN_2: nxt_state = ST_RUN;
         ST_RUN: begin
            if (dp_ready && (word_cnt == '0)) nxt_state = ST_DONE;
         end
         ST_DONE: nxt_state = ST_IDLE;
         default: nxt_state = ST_IDLE;
      endcase
`ifdef CIPHER_SCHED_TIMEOUT_EN
      if ((cur_state == ST_RUN) && !dp_ready && (stall_cnt == STALL_W'(TMO_CYC - 1))) begin
         timeout   = 1'b1;
         nxt_state = ST_IDLE;
      end
`endif
      // Losing the owner's request overrides everything, including the last word
      if (owns_dp && !req[owner_id]) begin
         abort     = 1'b1;
         timeout   = 1'b0;
         nxt_state = ST_IDLE;
      end
   end

   assign sel_id   = take_grant ? arb_id : owner_id;
   assign sel_mode = take_grant ? mode[arb_id] : owner_mode;
   assign word_vld = (cur_state == ST_RUN) && dp_ready;
   assign state    = cur_state;

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clka) begin
      if (restart) begin
         cur_state  <= ST_IDLE;
         owner_id   <= 1'b0;
         owner_mode <= 1'b0;
         word_cnt   <= '0;
         rr_ptr     <= 1'b0;
         gnt        <= 2'b00;
         key_gen    <= 1'b0;
         outcode    <= 1'b0;
         done       <= 2'b00;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (take_grant) begin
            owner_id   <= arb_id;
            owner_mode <= mode[arb_id];
            word_cnt   <= arb_id ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
         end else if ((cur_state == ST_RUN) && dp_ready && (word_cnt != '0)) begin
            word_cnt <= word_cnt - 1'b1;
         end
         if ((cur_state == ST_DONE) || abort || timeout) rr_ptr <= owner_id;
         if ((nxt_state == ST_KEY_GEN_1) || (nxt_state == ST_KEY_GEN_2) || (nxt_state == ST_RUN))
            gnt <= {sel_id, ~sel_id};
         else
            gnt <= 2'b00;
         {key_gen, outcode} <= ctrl_for(nxt_state, sel_mode);
         done <= (nxt_state == ST_DONE) ? {owner_id, ~owner_id} : 2'b00;
         busy <= (nxt_state != ST_IDLE);
         err  <= timeout;
      end
   end

`ifdef CIPHER_SCHED_TIMEOUT_EN
   // Consecutive stalled RUN cycles; any accepted word or leaving RUN clears it
   always_ff @(posedge clka) begin
      if (restart)
         stall_cnt <= '0;
      else if ((cur_state == ST_RUN) && !dp_ready && (nxt_state == ST_RUN))
         stall_cnt <= stall_cnt + 1'b1;
      else
         stall_cnt <= '0;
   end
`endif

endmodule
